// File: rtl/crypto_sched_pkg.sv
// rtl/crypto_sched_pkg.sv - shared types and defaults for the crypto engine scheduler
package crypto_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 64;
    localparam int TIMEOUT_DEF = 255;

    localparam logic OP_ENC = 1'b1;
    localparam logic OP_DEC = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    // Width of a counter that must hold values 0..max_val inclusive
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/crypto_rr_scheduler_rr_pick.sv
// rtl/crypto_rr_scheduler_rr_pick.sv - combinational round-robin picker (first request at or above pointer)
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Scan N slots starting at ptr, wrapping modulo N; first asserted request wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/crypto_rr_scheduler.sv
// rtl/crypto_rr_scheduler.sv - round-robin sharing of one crypto engine between request channels
module crypto_rr_scheduler
    import crypto_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_op,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic                      core_op,
    output logic [DATA_W-1:0]         core_din,
    input  logic                      core_done,
    input  logic [DATA_W-1:0]         core_dout,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int IW   = $clog2(N_REQ);
    localparam int WD_W = cnt_w(TIMEOUT);

    sched_state_e state, state_nxt;

    logic [IW-1:0]     rr_ptr;
    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DATA_W-1:0] sel_data;
    logic              sel_op;
    logic [N_REQ-1:0]  owner_mask;
    logic              rsp_fire;
    logic [WD_W-1:0]   wd;
    logic              timeout_hit;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Route the winning channel's block/op and decode the owner of the current grant
    always_comb begin
        sel_data   = '0;
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
            owner_mask[i] = (grant_id == IW'(i));
        end
    end

    assign sel_op      = |(req_op & pick_grant);
    assign rsp_fire    = |(rsp_ready & owner_mask);
    assign timeout_hit = (wd == WD_W'(TIMEOUT - 1));
    assign busy        = (state != S_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake strobes; req_ready is only offered while idle
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = pick_grant;
                if (pick_any) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (core_done || timeout_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = owner_mask;
                if (rsp_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, run watchdog, capture result or abort, advance pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            core_din <= '0;
            core_op  <= OP_DEC;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            wd       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        core_din <= sel_data;
                        core_op  <= sel_op;
                        grant_id <= pick_idx;
                    end
                end
                S_ISSUE: begin
                    wd <= '0;
                end
                S_WAIT: begin
                    wd <= wd + 1'b1;
                    // A completion arriving on the expiry cycle still counts as success
                    if (core_done) begin
                        rsp_data <= core_dout;
                        rsp_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_rr_scheduler.sv
// tb/tb_crypto_rr_scheduler.sv - directed self-checking bench for crypto_rr_scheduler
module tb_crypto_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_op;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           core_start;
    logic           core_op;
    logic [W-1:0]   core_din;
    logic           core_done;
    logic [W-1:0]   core_dout;
    logic           busy;
    logic [1:0]     grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    crypto_rr_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .core_start (core_start),
        .core_op    (core_op),
        .core_din   (core_din),
        .core_done  (core_done),
        .core_dout  (core_dout),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_op    = '0;
        rsp_ready = '0;
        core_done = 1'b0;
        core_dout = '0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_core_din", core_din, 64'd0);

        // Single request on ch2, encrypt
        req_valid = 4'b0100;
        req_op    = 4'b0100;
        req_data[2*W +: W] = 64'h0123456789ABCDEF;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'h4);
        chk("t1_no_start_idle", 64'(core_start), 64'd0);
        cyc();
        req_valid = '0;
        chk("t1_core_start", 64'(core_start), 64'd1);
        chk("t1_core_din", core_din, 64'h0123456789ABCDEF);
        chk("t1_core_op", 64'(core_op), 64'd1);
        chk("t1_grant_id", 64'(grant_id), 64'd2);
        chk("t1_busy", 64'(busy), 64'd1);
        cyc();
        chk("t1_start_pulse", 64'(core_start), 64'd0);
        cyc(); cyc(); cyc(); cyc();
        core_done = 1'b1;
        core_dout = 64'hDEADBEEFCAFEF00D;
        #1;
        chk("t1_no_rsp_yet", 64'(rsp_valid), 64'd0);
        cyc();
        core_done = 1'b0;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("t1_rsp_data", rsp_data, 64'hDEADBEEFCAFEF00D);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        rsp_ready = 4'b0100;
        cyc();
        rsp_ready = '0;
        chk("t1_idle_busy", 64'(busy), 64'd0);
        chk("t1_idle_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("t1_ptr_is_3", 64'(req_ready), 64'h8);
        req_valid = '0;

        // Reset, then all four channels request continuously
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_valid = 4'b1111;
        req_op    = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t2_req_ready", 64'(req_ready), 64'(1 << order[j]));
            cyc();
            chk("t2_grant_id", 64'(grant_id), 64'(order[j]));
            chk("t2_core_start", 64'(core_start), 64'd1);
            cyc();
            core_done = 1'b1;
            core_dout = 64'hA000 + 64'(j);
            cyc();
            core_done = 1'b0;
            chk("t2_rsp_valid", 64'(rsp_valid), 64'(1 << order[j]));
            chk("t2_rsp_data", rsp_data, 64'hA000 + 64'(j));
            rsp_ready = 4'b1111;
            cyc();
            rsp_ready = '0;
        end
        req_valid = '0;
        #1;

        // Timeout: ch1 request, engine never completes
        req_valid = 4'b0010;
        req_data[1*W +: W] = 64'h5555AAAA5555AAAA;
        cyc();
        req_valid = '0;
        cyc();
        for (int k = 0; k < TO; k++) begin
            chk("t3_wait_no_rsp", 64'(rsp_valid), 64'd0);
            cyc();
        end
        chk("t3_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t3_rsp_err", 64'(rsp_err), 64'd1);
        chk("t3_rsp_data", rsp_data, 64'd0);
        rsp_ready = 4'b0010;
        cyc();
        rsp_ready = '0;

        // Completion on the expiry cycle: ch3, done wins over timeout
        req_valid = 4'b1000;
        req_op    = 4'b1000;
        req_data[3*W +: W] = 64'h0F0F0F0F0F0F0F0F;
        #1;
        chk("t4_req_ready", 64'(req_ready), 64'h8);
        cyc();
        req_valid = '0;
        chk("t4_core_op", 64'(core_op), 64'd1);
        cyc();
        for (int k = 0; k < TO - 1; k++) cyc();
        core_done = 1'b1;
        core_dout = 64'h1122334455667788;
        cyc();
        core_done = 1'b0;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h8);
        chk("t4_rsp_err", 64'(rsp_err), 64'd0);
        chk("t4_rsp_data", rsp_data, 64'h1122334455667788);
        rsp_ready = 4'b1000;
        cyc();
        rsp_ready = '0;

        // Response back-pressure: ch0 held 10 cycles, stray done ignored
        req_valid = 4'b0001;
        req_op    = 4'b0001;
        req_data[0*W +: W] = 64'h00000000BADC0FFE;
        #1;
        chk("t5_req_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = '0;
        cyc();
        core_done = 1'b1;
        core_dout = 64'hFEEDFACE12345678;
        cyc();
        core_done = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t5_hold_valid", 64'(rsp_valid), 64'h1);
            chk("t5_hold_data", rsp_data, 64'hFEEDFACE12345678);
            chk("t5_hold_err", 64'(rsp_err), 64'd0);
            chk("t5_no_req_ready", 64'(req_ready), 64'd0);
            core_done = (k == 3);
            core_dout = 64'h9999999999999999;
            cyc();
        end
        core_done = 1'b0;
        chk("t5_after_stray", rsp_data, 64'hFEEDFACE12345678);
        rsp_ready = 4'b0001;
        cyc();
        rsp_ready = '0;
        #1;
        chk("t5_next_ptr", 64'(req_ready), 64'h2);
        req_valid = '0;

        // Reset during WAIT on ch1
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        chk("t6_busy_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_busy", 64'(busy), 64'd0);
        chk("t6_async_grant", 64'(grant_id), 64'd0);
        chk("t6_async_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_async_core_start", 64'(core_start), 64'd0);
        chk("t6_async_core_din", core_din, 64'd0);
        #1;
        rst = 1'b0;
        cyc();
        core_done = 1'b1;
        core_dout = 64'h7777777777777777;
        cyc();
        core_done = 1'b0;
        cyc();
        chk("t6_no_late_rsp", 64'(rsp_valid), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("t6_ptr_zero", 64'(req_ready), 64'h1);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
